// File: rtl/echo_pkg.sv
// Shared definitions for the Echo request-side demarshaller.
package echo_pkg;

  // Method id that decodes to Echo.say.
  localparam logic [15:0] ECHO_SAY_METHOD = 16'h0000;

  // Header word layout: [31:16] method id, [15:0] payload length in words.
  localparam int unsigned METHOD_HI = 31;
  localparam int unsigned METHOD_LO = 16;
  localparam int unsigned LEN_HI    = 15;
  localparam int unsigned LEN_LO    = 0;

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD,
    DISCARD
  } state_t;

endpackage

// File: rtl/fifo_n.sv
// DEPTH x 32 registered FIFO with enq/deq/first and __RDY guards.
// Not transparent: an entry pushed into an empty FIFO appears at first on the next cycle.
module fifo_n #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enq__ENA,
  input  logic [31:0] enq_v,
  output logic        enq__RDY,
  input  logic        deq__ENA,
  output logic        deq__RDY,
  output logic [31:0] first
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == FULL_CNT);
  assign deq__RDY = (r_count != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign enq__RDY = !w_full || deq__ENA;
  assign w_push   = enq__ENA && enq__RDY;
  assign w_pop    = deq__ENA && deq__RDY;
  assign first    = deq__RDY ? r_mem[r_rd_ptr] : 32'h0;

  // Storage write; contents need no reset since r_count gates visibility.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= enq_v;
    end
  end

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/echo_request_input.sv
// Parses framed request words from the host pipe and feeds say(v) arguments to Echo.
// Malformed or unknown messages are discarded and counted in err_count.
module echo_request_input
  import echo_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic [15:0] SAY_METHOD = ECHO_SAY_METHOD,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pipe__ENA,
  input  logic [31:0]      pipe_v,
  output logic             pipe__RDY,
  output logic             say__ENA,
  output logic [31:0]      say_v,
  input  logic             say__RDY,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  state_t           r_state;
  logic [15:0]      r_remaining;
  logic [CNT_W-1:0] r_msg_count;
  logic [CNT_W-1:0] r_err_count;

  state_t           w_state_d;
  logic [15:0]      w_remaining_d;
  logic [CNT_W-1:0] w_msg_d;
  logic [CNT_W-1:0] w_err_d;
  logic             w_enq;
  logic             w_enq_rdy;
  logic             w_not_empty;
  logic             w_accept;
  logic [15:0]      w_method;
  logic [15:0]      w_len;

  assign w_method  = pipe_v[METHOD_HI:METHOD_LO];
  assign w_len     = pipe_v[LEN_HI:LEN_LO];
  assign pipe__RDY = (r_state == PAYLOAD) ? w_enq_rdy : 1'b1;
  assign w_accept  = pipe__ENA && pipe__RDY;
  assign say__ENA  = w_not_empty && say__RDY;
  assign busy      = (r_state != HDR) || w_not_empty;
  assign msg_count = r_msg_count;
  assign err_count = r_err_count;

  fifo_n #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .enq__ENA (w_enq),
    .enq_v    (pipe_v),
    .enq__RDY (w_enq_rdy),
    .deq__ENA (say__ENA),
    .deq__RDY (w_not_empty),
    .first    (say_v)
  );

  // Header decode, payload capture, discard countdown and saturating statistics.
  always_comb begin
    w_state_d     = r_state;
    w_remaining_d = r_remaining;
    w_msg_d       = r_msg_count;
    w_err_d       = r_err_count;
    w_enq         = 1'b0;
    unique case (r_state)
      HDR: begin
        if (w_accept) begin
          if (w_method == SAY_METHOD && w_len == 16'd1) begin
            w_state_d = PAYLOAD;
          end else begin
            if (r_err_count != {CNT_W{1'b1}}) begin
              w_err_d = r_err_count + 1'b1;
            end
            // Zero-length messages have nothing to skip; stay and parse the next header.
            if (w_len != 16'd0) begin
              w_state_d     = DISCARD;
              w_remaining_d = w_len;
            end
          end
        end
      end
      PAYLOAD: begin
        if (w_accept) begin
          w_enq     = 1'b1;
          w_state_d = HDR;
          if (r_msg_count != {CNT_W{1'b1}}) begin
            w_msg_d = r_msg_count + 1'b1;
          end
        end
      end
      DISCARD: begin
        if (w_accept) begin
          w_remaining_d = r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            w_state_d = HDR;
          end
        end
      end
      default: begin
        w_state_d = HDR;
      end
    endcase
  end

  // State and counter registers; reset drops any partial message.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= HDR;
      r_remaining <= '0;
      r_msg_count <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_remaining <= w_remaining_d;
      r_msg_count <= w_msg_d;
      r_err_count <= w_err_d;
    end
  end

endmodule

// File: tb/tb_echo_request_input.sv
// Scoreboard bench for echo_request_input: the driver pushes expected say arguments,
// an independent monitor pops and compares whenever say__ENA is seen.
module tb_echo_request_input;
  import echo_pkg::*;

  localparam int CW = 4;  // narrow counters so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          pipe__ENA = 1'b0;
  logic [31:0]   pipe_v = 32'h0;
  logic          pipe__RDY;
  logic          say__ENA;
  logic [31:0]   say_v;
  logic          say__RDY = 1'b0;
  logic [CW-1:0] msg_count;
  logic [CW-1:0] err_count;
  logic          busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          exp_msg = 0;
  int          exp_err = 0;
  bit          rand_rdy = 1'b0;

  echo_request_input #(
    .DEPTH      (2),
    .SAY_METHOD (ECHO_SAY_METHOD),
    .CNT_W      (CW)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .pipe__ENA (pipe__ENA),
    .pipe_v    (pipe_v),
    .pipe__RDY (pipe__RDY),
    .say__ENA  (say__ENA),
    .say_v     (say_v),
    .say__RDY  (say__RDY),
    .msg_count (msg_count),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= CMAX) ? x : x + 1;
  endfunction

  // Monitor: every say delivered must be the oldest outstanding expected argument.
  always @(negedge CLK) begin
    if (nRST && say__ENA) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL say_unexpected: got say_v %h expected no say", say_v);
      end else begin
        check("say_v", say_v, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; holds the word until it is accepted, returns at posedge+1.
  task automatic send_word(input logic [31:0] w);
    bit done = 1'b0;
    int t = 0;
    pipe__ENA = 1'b1;
    pipe_v    = w;
    while (!done) begin
      if (rand_rdy) say__RDY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      done = pipe__RDY;
      @(posedge CLK);
      #1;
      t++;
      if (!done && t > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: word %h not accepted after %0d cycles", w, t);
        done = 1'b1;
      end
    end
    pipe__ENA = 1'b0;
  endtask

  // Model: a message is a say iff method matches and length is exactly 1.
  task automatic send_msg(input logic [15:0] m, input logic [15:0] l);
    logic [31:0] p;
    if (m == ECHO_SAY_METHOD && l == 16'd1) begin
      p = $urandom;
      exp_q.push_back(p);
      exp_msg = sat(exp_msg);
      send_word({m, l});
      send_word(p);
    end else begin
      exp_err = sat(exp_err);
      send_word({m, l});
      for (int i = 0; i < int'(l); i++) send_word($urandom);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_msg_count"}, 32'(msg_count), 32'(exp_msg));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
  endtask

  task automatic drain(input string tag);
    int t = 0;
    say__RDY = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_drain: %0d says still outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check_counts(tag);
  endtask

  initial begin
    logic [31:0] p;
    int          k;

    // Reset state.
    say__RDY = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_say_ena", 32'(say__ENA), 0);
    check("rst_say_v", say_v, 0);
    check("rst_pipe_rdy", 32'(pipe__RDY), 1);
    check_counts("rst");
    say__RDY = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Single say: one-cycle latency, not transparent.
    say__RDY = 1'b1;
    send_word(32'h0000_0001);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_msg = sat(exp_msg);
    pipe__ENA = 1'b1;
    pipe_v    = 32'hDEAD_BEEF;
    @(negedge CLK);
    check("t1_pipe_rdy", 32'(pipe__RDY), 1);
    check("t1_not_transparent", 32'(say__ENA), 0);
    @(posedge CLK);
    #1;
    pipe__ENA = 1'b0;
    check("t1_say_ena", 32'(say__ENA), 1);
    check("t1_say_v", say_v, 32'hDEAD_BEEF);
    check_counts("t1");
    drain("t1");

    // Four says with Echo blocked: FIFO fills, third payload stalls.
    say__RDY = 1'b0;
    send_msg(ECHO_SAY_METHOD, 16'd1);
    send_msg(ECHO_SAY_METHOD, 16'd1);
    p = $urandom;
    exp_q.push_back(p);
    exp_msg = sat(exp_msg);
    send_word(32'h0000_0001);
    pipe__ENA = 1'b1;
    pipe_v    = p;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t2_stall_rdy", 32'(pipe__RDY), 0);
      @(posedge CLK);
      #1;
    end
    check("t2_busy", 32'(busy), 1);
    say__RDY = 1'b1;
    send_word(p);
    send_msg(ECHO_SAY_METHOD, 16'd1);
    drain("t2");

    // Unknown method with three payload words, then a valid say.
    send_msg(16'h0005, 16'd3);
    check("t3_busy_hdr", 32'(busy), 0);
    check_counts("t3_discard");
    send_msg(ECHO_SAY_METHOD, 16'd1);
    drain("t3");

    // Zero-length header: stay in HDR, next word is a header.
    send_msg(16'h0000, 16'd0);
    check("t4_busy_hdr", 32'(busy), 0);
    send_msg(ECHO_SAY_METHOD, 16'd1);
    drain("t4");

    // Full FIFO: pop and push in the same cycle keeps occupancy at DEPTH.
    say__RDY = 1'b0;
    send_msg(ECHO_SAY_METHOD, 16'd1);
    send_msg(ECHO_SAY_METHOD, 16'd1);
    p = $urandom;
    exp_q.push_back(p);
    exp_msg = sat(exp_msg);
    send_word(32'h0000_0001);
    pipe__ENA = 1'b1;
    pipe_v    = p;
    say__RDY  = 1'b1;
    @(negedge CLK);
    check("t5_simul_rdy", 32'(pipe__RDY), 1);
    check("t5_simul_ena", 32'(say__ENA), 1);
    @(posedge CLK);
    #1;
    pipe__ENA = 1'b0;
    say__RDY  = 1'b0;
    p = $urandom;
    exp_q.push_back(p);
    exp_msg = sat(exp_msg);
    send_word(32'h0000_0001);
    pipe__ENA = 1'b1;
    pipe_v    = p;
    @(negedge CLK);
    check("t5_still_full", 32'(pipe__RDY), 0);
    @(posedge CLK);
    #1;
    say__RDY = 1'b1;
    send_word(p);
    drain("t5");

    // Maximum length discard.
    send_msg(16'h0007, 16'hFFFF);
    check("t6_busy_hdr", 32'(busy), 0);
    send_msg(ECHO_SAY_METHOD, 16'd1);
    drain("t6");

    // Randomized message mix with a randomly toggling say guard; counters saturate.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      case (k)
        0, 1: send_msg(ECHO_SAY_METHOD, 16'd1);
        2: send_msg(16'($urandom), 16'd0);
        3: send_msg(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 3)));
        default: send_msg(ECHO_SAY_METHOD, 16'($urandom_range(2, 4)));
      endcase
    end
    rand_rdy = 1'b0;
    drain("rand");

    // Asynchronous reset mid-discard with two buffered entries.
    say__RDY = 1'b0;
    send_msg(ECHO_SAY_METHOD, 16'd1);
    send_msg(ECHO_SAY_METHOD, 16'd1);
    send_word(32'h0005_0003);
    send_word($urandom);
    #1;
    say__RDY = 1'b1;
    #1;
    nRST = 1'b0;
    #1;
    exp_q.delete();
    exp_msg = 0;
    exp_err = 0;
    check("arst_busy", 32'(busy), 0);
    check("arst_say_ena", 32'(say__ENA), 0);
    check("arst_say_v", say_v, 0);
    check_counts("arst");
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    send_msg(ECHO_SAY_METHOD, 16'd1);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
